// File: rtl/line_memory.sv
// line_memory: DEPTH-line store feeding the FMA array via SMA/LOADI/LOADB/WRITEB/COMMIT; define LINE_MEMORY_PERF_EN for write/read counters
module line_memory #(
   parameter int FMA_COUNT = 2,
   parameter int WORD_WIDTH = 16,
   parameter int DEPTH = 375,
   parameter int INSTRUCTION_WIDTH = 32,
   localparam int LINE_WIDTH = FMA_COUNT*3*WORD_WIDTH,
   localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                         clk_in,
   input  logic                         rst_in,
   input  logic [INSTRUCTION_WIDTH-1:0] instr_in,
   input  logic                         instr_valid_in,
   output logic                         instr_ready_out,
   input  logic [LINE_WIDTH-1:0]        buffer_read_in,
   output logic [LINE_WIDTH-1:0]        abc_out,
   output logic                         abc_valid_out,
   input  logic                         abc_ready_in
`ifdef LINE_MEMORY_PERF_EN
   ,
   output logic [15:0]                  wr_count_out,
   output logic [15:0]                  rd_count_out
`endif
);
   localparam int WORDS = FMA_COUNT*3;
   localparam logic [3:0] OP_SMA = 4'b0110, OP_LOADI = 4'b0111, OP_LOADB = 4'b1000,
                          OP_WRITEB = 4'b1001, OP_COMMIT = 4'b1010;
   typedef enum logic [1:0] {IDLE, RD1, RD2, HOLD} state_t;
   state_t state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d, rd_addr_q;
   logic [LINE_WIDTH-1:0] stg_q, stg_d, rd_data_q, abc_q, abc_d, wr_data;
   logic [LINE_WIDTH-1:0] mem [DEPTH];
   logic [3:0] op, reg_a;
   logic [15:0] imm;
   logic acc, wr_en, rd_go, inc, unused_bits;
   assign op = instr_in[31:28];
   assign reg_a = instr_in[27:24];
   assign imm = instr_in[23:8];
   assign unused_bits = ^{instr_in[7:5], instr_in[3:0]};
   assign acc = instr_valid_in && instr_ready_out;
   assign wr_en = acc && (op == OP_COMMIT || op == OP_LOADB);
   assign rd_go = acc && op == OP_WRITEB;
   assign inc = instr_in[4] && (op == OP_COMMIT || op == OP_LOADB || op == OP_WRITEB);
   assign wr_data = op == OP_COMMIT ? stg_q : buffer_read_in;
   assign abc_out = abc_q;
   // FSM state register
   always_ff @(posedge clk_in or negedge rst_in)
      if (!rst_in) state_q <= IDLE;
      else state_q <= state_d;
   // read path sequencing: two BRAM latency cycles, then hold until downstream takes the line
   always_comb begin
      state_d = state_q == IDLE ? (rd_go ? RD1 : IDLE) :
                state_q == RD1  ? RD2 :
                state_q == RD2  ? HOLD :
                (abc_ready_in ? IDLE : HOLD);
   end
   // handshake outputs; ready is held low while reset is asserted
   always_comb begin
      instr_ready_out = rst_in && state_q == IDLE;
      abc_valid_out = state_q == HOLD;
   end
   // next address, staging words and output line
   always_comb begin
      addr_d = addr_q;
      if (acc && op == OP_SMA) addr_d = ({16'd0, imm} < 32'(DEPTH)) ? imm[ADDR_WIDTH-1:0] : '0;
      else if (acc && inc) addr_d = (addr_q == ADDR_WIDTH'(DEPTH-1)) ? '0 : addr_q + ADDR_WIDTH'(1);
      stg_d = stg_q;
      for (int i = 0; i < WORDS; i++)
         stg_d[i*WORD_WIDTH +: WORD_WIDTH] = (acc && op == OP_COMMIT) ? '0 :
            (acc && op == OP_LOADI && reg_a == 4'(i)) ? WORD_WIDTH'(imm) :
            stg_q[i*WORD_WIDTH +: WORD_WIDTH];
      abc_d = state_q == RD2 ? rd_data_q : abc_q;
   end
   // architectural registers cleared by reset
   always_ff @(posedge clk_in or negedge rst_in)
      if (!rst_in) begin
         addr_q <= '0;
         stg_q <= '0;
         abc_q <= '0;
      end else begin
         addr_q <= addr_d;
         stg_q <= stg_d;
         abc_q <= abc_d;
      end
   // line storage with registered read; contents survive reset, read address latched on accept
   always_ff @(posedge clk_in) begin
      if (wr_en) mem[addr_q] <= wr_data;
      if (rd_go) rd_addr_q <= addr_q;
      rd_data_q <= mem[rd_addr_q];
   end
`ifdef LINE_MEMORY_PERF_EN
   logic [15:0] wr_cnt_q, rd_cnt_q;
   // saturating access counters
   always_ff @(posedge clk_in or negedge rst_in)
      if (!rst_in) begin
         wr_cnt_q <= '0;
         rd_cnt_q <= '0;
      end else begin
         wr_cnt_q <= (wr_en && wr_cnt_q != 16'hFFFF) ? wr_cnt_q + 16'd1 : wr_cnt_q;
         rd_cnt_q <= (state_q == HOLD && abc_ready_in && rd_cnt_q != 16'hFFFF) ? rd_cnt_q + 16'd1 : rd_cnt_q;
      end
   assign wr_count_out = wr_cnt_q;
   assign rd_count_out = rd_cnt_q;
`endif
endmodule

// File: tb/tb_line_memory.sv
// tb_line_memory: directed self-checking bench for line_memory
module tb_line_memory;
   localparam int LW = 96;
   localparam logic [3:0] OP_SMA = 4'b0110, OP_LOADI = 4'b0111, OP_LOADB = 4'b1000,
                          OP_WRITEB = 4'b1001, OP_COMMIT = 4'b1010, OP_BAD = 4'b1111;
   localparam logic [LW-1:0] LX = 96'h1, LY = 96'h2, LZ = 96'h5A5A;
   logic clk_in = 0, rst_in = 0, instr_valid_in = 0, abc_ready_in = 1;
   logic [31:0] instr_in = '0;
   logic [LW-1:0] buffer_read_in = '0;
   logic [LW-1:0] abc_out;
   logic instr_ready_out, abc_valid_out;
   int n_cmp = 0, n_err = 0;
`ifdef LINE_MEMORY_PERF_EN
   logic [15:0] wr_count_out, rd_count_out;
`endif
   line_memory dut (
      .clk_in(clk_in), .rst_in(rst_in), .instr_in(instr_in), .instr_valid_in(instr_valid_in),
      .instr_ready_out(instr_ready_out), .buffer_read_in(buffer_read_in), .abc_out(abc_out),
      .abc_valid_out(abc_valid_out), .abc_ready_in(abc_ready_in)
`ifdef LINE_MEMORY_PERF_EN
      , .wr_count_out(wr_count_out), .rd_count_out(rd_count_out)
`endif
   );
   always #5 clk_in = ~clk_in;

   function automatic logic [31:0] mk(input logic [3:0] op, input logic [3:0] ra, input logic [15:0] imm, input logic [3:0] rb);
      return {op, ra, imm, rb, 4'h0};
   endfunction

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic issue(input logic [31:0] ins);
      int n = 0;
      instr_in = ins;
      instr_valid_in = 1;
      while (instr_ready_out !== 1'b1 && n < 10) begin
         step();
         n++;
      end
      if (n == 10) begin
         n_cmp++;
         n_err++;
         $display("FAIL issue_timeout: instr_ready_out=%b required 1", instr_ready_out);
      end
      step();
      instr_valid_in = 0;
   endtask

   task automatic read_line(input logic [3:0] rb, output logic [LW-1:0] data);
      int n = 0;
      issue(mk(OP_WRITEB, 4'h0, 16'h0, rb));
      while (abc_valid_out !== 1'b1 && n < 10) begin
         step();
         n++;
      end
      if (abc_valid_out !== 1'b1) begin
         n_cmp++;
         n_err++;
         $display("FAIL read_timeout: abc_valid_out=%b required 1", abc_valid_out);
      end
      data = abc_out;
      step();
   endtask

   task automatic test_reset();
      step();
      step();
      n_cmp++;
      if (instr_ready_out !== 1'b0 || abc_valid_out !== 1'b0 || abc_out !== '0) begin
         n_err++;
         $display("FAIL reset_hold: ready=%b valid=%b abc=%h required 0 0 0", instr_ready_out, abc_valid_out, abc_out);
      end
      rst_in = 1;
      step();
      n_cmp++;
      if (instr_ready_out !== 1'b1 || abc_valid_out !== 1'b0) begin
         n_err++;
         $display("FAIL reset_release: ready=%b valid=%b required 1 0", instr_ready_out, abc_valid_out);
      end
   endtask

   task automatic test_staging();
      logic [LW-1:0] d;
      localparam logic [LW-1:0] EXP = 96'h8883_8884_8885_8886_8887_8888;
      issue(mk(OP_SMA, 4'h0, 16'h0178, 4'h0));
      for (int i = 0; i < 6; i++) issue(mk(OP_LOADI, 4'(i), 16'h8888 - 16'(i), 4'h0));
      issue(mk(OP_COMMIT, 4'h0, 16'h0, 4'h0));
      issue(mk(OP_WRITEB, 4'h0, 16'h0, 4'h0));
      n_cmp++;
      if (abc_valid_out !== 1'b0 || instr_ready_out !== 1'b0) begin
         n_err++;
         $display("FAIL stg_rd1: valid=%b ready=%b required 0 0", abc_valid_out, instr_ready_out);
      end
      step();
      n_cmp++;
      if (abc_valid_out !== 1'b0) begin
         n_err++;
         $display("FAIL stg_rd2: valid=%b required 0", abc_valid_out);
      end
      step();
      n_cmp++;
      if (abc_valid_out !== 1'b1 || abc_out !== EXP) begin
         n_err++;
         $display("FAIL stg_data: valid=%b abc=%h required 1 %h", abc_valid_out, abc_out, EXP);
      end
      step();
      n_cmp++;
      if (abc_valid_out !== 1'b0 || instr_ready_out !== 1'b1) begin
         n_err++;
         $display("FAIL stg_done: valid=%b ready=%b required 0 1", abc_valid_out, instr_ready_out);
      end
      issue(mk(OP_SMA, 4'h0, 16'h0000, 4'h0));
      read_line(4'h0, d);
      n_cmp++;
      if (d !== EXP) begin
         n_err++;
         $display("FAIL sma_clamp: abc=%h required %h", d, EXP);
      end
   endtask

   task automatic test_loadb();
      logic [LW-1:0] d;
      localparam logic [LW-1:0] EXP = 96'hA000_A000_A000_A000_A000_A000;
      issue(mk(OP_SMA, 4'h0, 16'h0178, 4'h0));
      buffer_read_in = EXP;
      issue(mk(OP_LOADB, 4'h0, 16'h0, 4'h0));
      buffer_read_in = '0;
      n_cmp++;
      if (instr_ready_out !== 1'b1) begin
         n_err++;
         $display("FAIL loadb_ready: ready=%b required 1", instr_ready_out);
      end
      read_line(4'h0, d);
      n_cmp++;
      if (d !== EXP) begin
         n_err++;
         $display("FAIL loadb_data: abc=%h required %h", d, EXP);
      end
   endtask

   task automatic test_backpressure();
      localparam logic [LW-1:0] EXP = 96'hA000_A000_A000_A000_A000_A000;
      abc_ready_in = 0;
      issue(mk(OP_WRITEB, 4'h0, 16'h0, 4'h0));
      step();
      step();
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if (abc_valid_out !== 1'b1 || abc_out !== EXP || instr_ready_out !== 1'b0) begin
            n_err++;
            $display("FAIL bp_hold%0d: valid=%b abc=%h ready=%b required 1 %h 0", i, abc_valid_out, abc_out, instr_ready_out, EXP);
         end
         step();
      end
      abc_ready_in = 1;
      step();
      n_cmp++;
      if (abc_valid_out !== 1'b0 || instr_ready_out !== 1'b1) begin
         n_err++;
         $display("FAIL bp_release: valid=%b ready=%b required 0 1", abc_valid_out, instr_ready_out);
      end
   endtask

   task automatic test_invalid();
      logic [LW-1:0] d;
      localparam logic [LW-1:0] EXP = 96'h1005_1004_1003_1002_1001_1000;
      for (int i = 0; i < 6; i++) issue(mk(OP_LOADI, 4'(i), 16'h1000 + 16'(i), 4'h0));
      issue(mk(OP_LOADI, 4'h6, 16'hFFFF, 4'h0));
      issue(mk(OP_LOADI, 4'hF, 16'hFFFF, 4'h0));
      issue(mk(OP_BAD, 4'h0, 16'hDEAD, 4'h1));
      issue(mk(OP_SMA, 4'h0, 16'h0005, 4'h0));
      issue(mk(OP_COMMIT, 4'h0, 16'h0, 4'h0));
      issue(mk(OP_BAD, 4'h1, 16'hBEEF, 4'h1));
      n_cmp++;
      if (instr_ready_out !== 1'b1) begin
         n_err++;
         $display("FAIL bad_op_ready: ready=%b required 1", instr_ready_out);
      end
      read_line(4'h0, d);
      n_cmp++;
      if (d !== EXP) begin
         n_err++;
         $display("FAIL invalid_loadi: abc=%h required %h", d, EXP);
      end
      issue(mk(OP_SMA, 4'h0, 16'h0006, 4'h0));
      issue(mk(OP_COMMIT, 4'h0, 16'h0, 4'h0));
      issue(mk(OP_SMA, 4'h0, 16'h0006, 4'h0));
      read_line(4'h0, d);
      n_cmp++;
      if (d !== '0) begin
         n_err++;
         $display("FAIL staging_clear: abc=%h required 0", d);
      end
   endtask

   task automatic test_autoinc_wrap();
      logic [LW-1:0] d;
      issue(mk(OP_SMA, 4'h0, 16'd1, 4'h0));
      buffer_read_in = LZ;
      issue(mk(OP_LOADB, 4'h0, 16'h0, 4'h0));
      issue(mk(OP_SMA, 4'h0, 16'd374, 4'h0));
      buffer_read_in = LX;
      issue(mk(OP_LOADB, 4'h0, 16'h0, 4'h1));
      buffer_read_in = LY;
      issue(mk(OP_LOADB, 4'h0, 16'h0, 4'h1));
      buffer_read_in = '0;
      read_line(4'h0, d);
      n_cmp++;
      if (d !== LZ) begin
         n_err++;
         $display("FAIL wrap_addr1: abc=%h required %h", d, LZ);
      end
      issue(mk(OP_SMA, 4'h0, 16'd374, 4'h0));
      read_line(4'h1, d);
      n_cmp++;
      if (d !== LX) begin
         n_err++;
         $display("FAIL wrap_last: abc=%h required %h", d, LX);
      end
      read_line(4'h0, d);
      n_cmp++;
      if (d !== LY) begin
         n_err++;
         $display("FAIL wrap_rd_inc: abc=%h required %h", d, LY);
      end
      issue(mk(OP_SMA, 4'h0, 16'd0, 4'h0));
      read_line(4'h0, d);
      n_cmp++;
      if (d !== LY) begin
         n_err++;
         $display("FAIL wrap_first: abc=%h required %h", d, LY);
      end
   endtask

   task automatic test_reset_mid_read();
      logic [LW-1:0] d;
      issue(mk(OP_LOADI, 4'h0, 16'h0077, 4'h0));
      issue(mk(OP_SMA, 4'h0, 16'd1, 4'h0));
      issue(mk(OP_WRITEB, 4'h0, 16'h0, 4'h0));
      step();
      rst_in = 0;
      #1;
      n_cmp++;
      if (abc_valid_out !== 1'b0 || instr_ready_out !== 1'b0) begin
         n_err++;
         $display("FAIL rst_mid: valid=%b ready=%b required 0 0", abc_valid_out, instr_ready_out);
      end
      step();
      step();
      rst_in = 1;
      #1;
      n_cmp++;
      if (instr_ready_out !== 1'b1) begin
         n_err++;
         $display("FAIL rst_mid_ready: ready=%b required 1", instr_ready_out);
      end
      for (int i = 0; i < 4; i++) begin
         step();
         n_cmp++;
         if (abc_valid_out !== 1'b0) begin
            n_err++;
            $display("FAIL rst_no_pulse%0d: valid=%b required 0", i, abc_valid_out);
         end
      end
      read_line(4'h0, d);
      n_cmp++;
      if (d !== LY) begin
         n_err++;
         $display("FAIL rst_addr0: abc=%h required %h", d, LY);
      end
      issue(mk(OP_SMA, 4'h0, 16'd7, 4'h0));
      issue(mk(OP_COMMIT, 4'h0, 16'h0, 4'h0));
      issue(mk(OP_SMA, 4'h0, 16'd7, 4'h0));
      read_line(4'h0, d);
      n_cmp++;
      if (d !== '0) begin
         n_err++;
         $display("FAIL rst_staging: abc=%h required 0", d);
      end
      abc_ready_in = 0;
      issue(mk(OP_SMA, 4'h0, 16'd374, 4'h0));
      issue(mk(OP_WRITEB, 4'h0, 16'h0, 4'h0));
      step();
      step();
      n_cmp++;
      if (abc_valid_out !== 1'b1 || abc_out !== LX) begin
         n_err++;
         $display("FAIL rst_hold_pre: valid=%b abc=%h required 1 %h", abc_valid_out, abc_out, LX);
      end
      #3 rst_in = 0;
      #1;
      n_cmp++;
      if (abc_valid_out !== 1'b0 || abc_out !== '0) begin
         n_err++;
         $display("FAIL rst_async: valid=%b abc=%h required 0 0", abc_valid_out, abc_out);
      end
      step();
      rst_in = 1;
      abc_ready_in = 1;
      step();
      issue(mk(OP_SMA, 4'h0, 16'd374, 4'h0));
      read_line(4'h0, d);
      n_cmp++;
      if (d !== LX) begin
         n_err++;
         $display("FAIL rst_mem_kept: abc=%h required %h", d, LX);
      end
   endtask

   initial begin
      test_reset();
      test_staging();
      test_loadb();
      test_backpressure();
      test_invalid();
      test_autoinc_wrap();
      test_reset_mid_read();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
